// File: rtl/alu_exec.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : alu_exec                                                        |
// | Desc   : valid/ready ALU with registered result and flags; the iterative |
// |          one-bit-per-cycle shifter is built only with ALU_EXEC_SHIFT_EN.  |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module alu_exec #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         alu_control_line,
    input  logic [DATA_W-1:0]  operand_a,
    input  logic [DATA_W-1:0]  operand_b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  result,
    output logic               zero,
    output logic               overflow,
    output logic               illegal_op
);

    localparam int         c_msb    = DATA_W - 1;
    localparam logic [3:0] c_op_and = 4'b0000;
    localparam logic [3:0] c_op_or  = 4'b0001;
    localparam logic [3:0] c_op_add = 4'b0010;
    localparam logic [3:0] c_op_sub = 4'b0110;
    localparam logic [3:0] c_op_slt = 4'b0111;
    localparam logic [3:0] c_op_xor = 4'b1000;
    localparam logic [3:0] c_op_nor = 4'b1100;
`ifdef ALU_EXEC_SHIFT_EN
    localparam logic [3:0] c_op_sll = 4'b0011;
    localparam logic [3:0] c_op_srl = 4'b0100;
    localparam logic [3:0] c_op_sra = 4'b0101;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
`ifdef ALU_EXEC_SHIFT_EN
        S_SHIFT = 2'd2,
`endif
        S_DONE  = 2'd1
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_result;
    logic                r_out_valid;
    logic                r_zero;
    logic                r_overflow;
    logic                r_illegal;

    logic                w_accept;
    logic [DATA_W-1:0]   w_sum;
    logic [DATA_W-1:0]   w_diff;
    logic                w_lt;
    logic [DATA_W-1:0]   w_alu_res;
    logic                w_alu_ovf;
    logic                w_alu_illegal;
    logic                w_shift_start;

    // A new request may enter while the previous result leaves in the same cycle.
    assign in_ready = !rst && ((r_state == S_IDLE) || ((r_state == S_DONE) && out_ready));
    assign w_accept = in_valid && in_ready;

    assign w_sum  = operand_a + operand_b;
    assign w_diff = operand_a - operand_b;
    assign w_lt   = $signed(operand_a) < $signed(operand_b);

    always_comb begin
        w_alu_res     = '0;
        w_alu_ovf     = 1'b0;
        w_alu_illegal = 1'b0;
        w_shift_start = 1'b0;
        case (alu_control_line)
            c_op_add: begin
                w_alu_res = w_sum;
                w_alu_ovf = (operand_a[c_msb] == operand_b[c_msb]) &&
                            (w_sum[c_msb] != operand_a[c_msb]);
            end
            c_op_sub: begin
                w_alu_res = w_diff;
                w_alu_ovf = (operand_a[c_msb] != operand_b[c_msb]) &&
                            (w_diff[c_msb] != operand_a[c_msb]);
            end
            c_op_and: w_alu_res = operand_a & operand_b;
            c_op_or:  w_alu_res = operand_a | operand_b;
            c_op_xor: w_alu_res = operand_a ^ operand_b;
            c_op_nor: w_alu_res = ~(operand_a | operand_b);
            c_op_slt: w_alu_res = {{(DATA_W-1){1'b0}}, w_lt};
`ifdef ALU_EXEC_SHIFT_EN
            // A zero shift completes immediately with operand_b unchanged.
            c_op_sll, c_op_srl, c_op_sra: begin
                w_alu_res     = operand_b;
                w_shift_start = (shamt != '0);
            end
`endif
            default:  w_alu_illegal = 1'b1;
        endcase
    end

`ifdef ALU_EXEC_SHIFT_EN
    logic [SHAMT_W-1:0] r_count;
    logic [3:0]         r_shift_op;
    logic [DATA_W-1:0]  w_shift_next;

    always_comb begin
        w_shift_next = r_result;
        case (r_shift_op)
            c_op_sll: w_shift_next = {r_result[c_msb-1:0], 1'b0};
            c_op_srl: w_shift_next = {1'b0, r_result[c_msb:1]};
            c_op_sra: w_shift_next = {r_result[c_msb], r_result[c_msb:1]};
            default:  w_shift_next = r_result;
        endcase
    end
`else
    logic w_unused_shamt;
    assign w_unused_shamt = ^shamt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_overflow  <= 1'b0;
            r_illegal   <= 1'b0;
`ifdef ALU_EXEC_SHIFT_EN
            r_count     <= '0;
            r_shift_op  <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
`ifdef ALU_EXEC_SHIFT_EN
                        if (w_shift_start) begin
                            r_state     <= S_SHIFT;
                            r_out_valid <= 1'b0;
                            r_result    <= operand_b;
                            r_count     <= shamt;
                            r_shift_op  <= alu_control_line;
                            r_zero      <= 1'b0;
                            r_overflow  <= 1'b0;
                            r_illegal   <= 1'b0;
                        end else
`endif
                        begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                            r_result    <= w_alu_res;
                            r_zero      <= (w_alu_res == '0);
                            r_overflow  <= w_alu_ovf;
                            r_illegal   <= w_alu_illegal;
                        end
                    end else if ((r_state == S_DONE) && out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
`ifdef ALU_EXEC_SHIFT_EN
                S_SHIFT: begin
                    r_result <= w_shift_next;
                    r_count  <= r_count - SHAMT_W'(1);
                    if (r_count == SHAMT_W'(1)) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_zero      <= (w_shift_next == '0);
                    end
                end
`endif
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid  = r_out_valid;
    assign result     = r_result;
    assign zero       = r_zero;
    assign overflow   = r_overflow;
    assign illegal_op = r_illegal;

endmodule
`default_nettype wire

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 SHALL provide parameter: DATA_W, 32, operand/result width (only 32 is supported).
REQ-002 SHALL provide parameter: SHAMT_W, 5, shift-amount width.
REQ-003 SHALL provide port: clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL provide port: rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL provide port: in_valid  input  1  request present.
REQ-006 SHALL provide port: in_ready  output  1  request accepted when in_valid && in_ready.
REQ-007 SHALL provide port: alu_control_line  input  4  operation code.
REQ-008 SHALL provide port: operand_a  input  DATA_W  rs operand.
REQ-009 SHALL provide port: operand_b  input  DATA_W  rt operand.
REQ-010 SHALL provide port: shamt  input  SHAMT_W  shift amount.
REQ-011 SHALL provide port: out_valid  output  1  result present.
REQ-012 SHALL provide port: out_ready  input  1  result consumed when out_valid && out_ready.
REQ-013 SHALL provide port: result  output  DATA_W  registered result.
REQ-014 SHALL provide ports: zero, overflow, illegal_op  output  1 each  registered flags qualified by out_valid.

Function
REQ-015 SHALL decode: 0010 add, 0110 sub, 0000 and, 0001 or, 1000 xor, 1100 nor, 0111 slt (signed, result 1 or 0); with shifter: 0011 sll, 0100 srl, 0101 sra, all shifting operand_b by shamt.
REQ-016 SHALL implement FSM IDLE -> (shift op, shamt!=0) SHIFT -> DONE; IDLE -> (all other ops) DONE; DONE -> IDLE on out_ready.
REQ-017 SHALL drive in_ready = 1 only in IDLE, or in DONE while out_ready=1 (back-to-back accept, zero bubble).
REQ-018 SHALL, for a non-shift op or shamt=0 accepted at edge N, assert out_valid after edge N+1 (1-cycle latency).
REQ-019 SHALL, for a shift op with shamt=k>0, shift one bit per cycle with a down-counter loaded with k and assert out_valid after edge N+1+k; in_ready=0 throughout SHIFT.
REQ-020 SHALL sign-fill on sra, zero-fill on sll/srl; shamt=0 yields result=operand_b.
REQ-021 SHALL set overflow only for add/sub signed overflow (operands same sign for add, different for sub, result sign differs); otherwise 0.
REQ-022 SHALL set zero = (result == 0) for every completed operation.
REQ-023 SHALL, for an undefined code, complete in 1 cycle with result=0, zero=1, overflow=0, illegal_op=1.
REQ-024 SHALL hold result and all flags stable while out_valid=1 and out_ready=0.
REQ-025 SHALL wrap add/sub modulo 2^DATA_W.
REQ-026 SHALL ignore in_valid and operand changes when in_ready=0.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, force state IDLE, out_valid=0, result=0, zero=0, overflow=0, illegal_op=0, counter=0.
REQ-028 SHALL abort any in-progress shift or pending result on reset, with no output produced for it.
REQ-029 SHALL drive in_ready=0 while rst=1.

Configuration
REQ-030 SHALL compile the iterative shifter (codes 0011/0100/0101 and SHIFT state) only when macro ALU_EXEC_SHIFT_EN is defined.
REQ-031 SHALL, without ALU_EXEC_SHIFT_EN, treat 0011/0100/0101 as undefined codes per REQ-023, with no SHIFT state or counter present.

Verification
REQ-032 SHALL cover: add 0x7FFFFFFF+0x00000001 -> result 0x80000000, overflow=1, zero=0, out_valid one cycle after accept.
REQ-033 SHALL cover: sub 5-5, then slt 0xFFFFFFFF vs 0x00000001 back-to-back with out_ready=1 -> results 0 (zero=1) then 1, no bubble.
REQ-034 SHALL cover: sra 0x80000000 by shamt=4 -> 0xF8000000 after 5 cycles, in_ready=0 during the 4 SHIFT cycles.
REQ-035 SHALL cover: nor 0 with 0 under out_ready=0 for 3 cycles -> 0xFFFFFFFF held stable, in_ready=0, released on out_ready=1.
REQ-036 SHALL cover: code 1111 -> result 0, illegal_op=1, zero=1; and rst pulsed mid-sll (shamt=20, cycle 7) -> out_valid=0, in_ready=1 on first cycle after rst deasserts.
